itrx_apbm_spi_sck_gen: RTL and testbench



---
 rtl/itrx_apbm_spi_pkg.sv | 19 +
 rtl/itrx_apbm_spi_half_period_cnt.sv | 44 ++++
 rtl/itrx_apbm_spi_sck_gen.sv | 170 +++++++++++++++++
 tb/tb_itrx_apbm_spi_sck_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/itrx_apbm_spi_pkg.sv
// Shared types and defaults for the APB-master SPI serial-clock path.
// Holds the SCK FSM state encoding, default widths and the edge-counter width helper.
package itrx_apbm_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } sck_state_e;

  localparam int unsigned SPI_DIV_W_DEF = 8;
  localparam int unsigned SPI_BIT_W_DEF = 6;

  // Two edges per bit, so one extra bit over the bit-count field covers 2*2^BIT_W edges.
  function automatic int unsigned edge_cnt_w(input int unsigned bit_w);
    return bit_w + 1;
  endfunction

endpackage

// File: rtl/itrx_apbm_spi_half_period_cnt.sv
// Half-period counter: counts 0..div_i and pulses wrap_o (combinationally) on the div_i cycle.
// hold_i freezes the counter only while it sits at div_i, deferring the wrap.
module itrx_apbm_spi_half_period_cnt
  import itrx_apbm_spi_pkg::*;
#(
  parameter int unsigned DIV_W = SPI_DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             hold_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             wrap_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             at_top;

  assign at_top = (cnt_q == div_i);
  assign wrap_o = en_i & at_top & ~hold_i & ~clr_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (!at_top) begin
        cnt_d = cnt_q + DIV_W'(1);
      end else if (!hold_i) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/itrx_apbm_spi_sck_gen.sv
// CPOL/CPHA-aware SPI SCK generator: bursts of nbits+1 bits, registered sck and strobes, busy/done.
// Edge k appears (k+1)*(div+1) cycles after busy rises; ITRX_SPI_SCK_STALL_EN lets stall_i defer edges.
module itrx_apbm_spi_sck_gen
  import itrx_apbm_spi_pkg::*;
#(
  parameter int unsigned DIV_W = SPI_DIV_W_DEF,
  parameter int unsigned BIT_W = SPI_BIT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             stall_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [BIT_W-1:0] nbits_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  output logic             sck_o,
  output logic             shift_o,
  output logic             sample_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned EDGE_W = edge_cnt_w(BIT_W);

  sck_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] nbits_q, nbits_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic             sck_q, sck_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             wrap;
  logic             last_edge;
  logic             cnt_clr;
  logic             stall_hold;

`ifdef ITRX_SPI_SCK_STALL_EN
  assign stall_hold = stall_i & (state_q == ST_RUN);
`else
  logic unused_stall;
  assign unused_stall = stall_i;
  assign stall_hold   = 1'b0;
`endif

  // Counter restarts from 0 on the accept cycle so T0 is count 0; abort also parks it.
  assign cnt_clr = (state_q == ST_IDLE) | abort_i;

  itrx_apbm_spi_half_period_cnt #(
    .DIV_W (DIV_W)
  ) u_half_period_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (state_q != ST_IDLE),
    .hold_i (stall_hold),
    .div_i  (div_q),
    .wrap_o (wrap)
  );

  assign last_edge = (edge_q == {nbits_q, 1'b1});

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    nbits_d  = nbits_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    edge_d   = edge_q;
    sck_d    = sck_q;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sck_d  = cpol_i;
        edge_d = '0;
        if (start_i && !abort_i) begin
          state_d = ST_RUN;
          div_d   = div_i;
          nbits_d = nbits_i;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          // CPHA=0 needs bit 0 on the line before the first (sampling) edge.
          shift_d = ~cpha_i;
        end
      end

      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          sck_d   = cpol_q;
        end else if (wrap) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + EDGE_W'(1);
          if (!edge_q[0]) begin
            shift_d  = cpha_q;
            sample_d = ~cpha_q;
          end else begin
            shift_d  = ~cpha_q & ~last_edge;
            sample_d = cpha_q;
          end
          if (last_edge) begin
            state_d = ST_TAIL;
          end
        end
      end

      ST_TAIL: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          sck_d   = cpol_q;
        end else if (wrap) begin
          state_d = ST_IDLE;
          sck_d   = cpol_q;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sck_d   = cpol_q;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      nbits_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      edge_q   <= '0;
      sck_q    <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      nbits_q  <= nbits_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      edge_q   <= edge_d;
      sck_q    <= sck_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sck_o    = sck_q;
  assign shift_o  = shift_q;
  assign sample_o = sample_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_itrx_apbm_spi_sck_gen.sv
// Directed bench for the SPI SCK generator: table of burst configurations plus corner sequences.
`timescale 1ns/1ps
module tb_itrx_apbm_spi_sck_gen;

  localparam int DIV_W = 8;
  localparam int BIT_W = 6;
`ifdef ITRX_SPI_SCK_STALL_EN
  localparam int STALL_DLY = 10;
`else
  localparam int STALL_DLY = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             stall_i = 1'b0;
  logic [DIV_W-1:0] div_i = '0;
  logic [BIT_W-1:0] nbits_i = '0;
  logic             cpol_i = 1'b0;
  logic             cpha_i = 1'b0;
  logic             sck_o, shift_o, sample_o, busy_o, done_o;

  always #5 clk = ~clk;

  itrx_apbm_spi_sck_gen #(.DIV_W(DIV_W), .BIT_W(BIT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .abort_i  (abort_i),
    .stall_i  (stall_i),
    .div_i    (div_i),
    .nbits_i  (nbits_i),
    .cpol_i   (cpol_i),
    .cpha_i   (cpha_i),
    .sck_o    (sck_o),
    .shift_o  (shift_o),
    .sample_o (sample_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle offsets are relative to the start_i cycle S (busy rises at offset 1).
  typedef struct {
    int div; int nbits; int cpol; int cpha;
    int e_first; int e_last; int e_done; int e_edges; int e_shift; int e_sample;
    int e_fsh; int e_lsh; int e_fsa; int e_lsa;
  } vec_t;

  vec_t vt[6];

  task automatic go(input int d, input int nb, input int cp, input int ch);
    div_i   = d[DIV_W-1:0];
    nbits_i = nb[BIT_W-1:0];
    cpol_i  = cp[0];
    cpha_i  = ch[0];
    @(posedge clk); #1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int edges = 0, nsh = 0, nsa = 0, stray = 0;
    int first = -1, last = -1, done_at = -1;
    int fsh = -1, lsh = -1, fsa = -1, lsa = -1;
    int busy_t0 = 0, busy_done = 1, sck_done = -1;
    logic prev_sck;
    div_i   = v.div[DIV_W-1:0];
    nbits_i = v.nbits[BIT_W-1:0];
    cpol_i  = v.cpol[0];
    cpha_i  = v.cpha[0];
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("v%0d_idle_sck", idx), int'(sck_o), v.cpol);
    @(posedge clk); #1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    // Config outside the accept cycle must be ignored.
    div_i   = ~div_i;
    nbits_i = ~nbits_i;
    cpha_i  = ~cpha_i;
    prev_sck = v.cpol[0];
    for (int t = 1; t <= v.e_done + 4; t++) begin
      @(negedge clk);
      if (t == 1) busy_t0 = int'(busy_o);
      if (sck_o != prev_sck) begin
        edges++;
        if (first < 0) first = t;
        last = t;
      end
      if (shift_o) begin
        nsh++; if (fsh < 0) fsh = t; lsh = t;
        if (sck_o == prev_sck) stray++;
      end
      if (sample_o) begin
        nsa++; if (fsa < 0) fsa = t; lsa = t;
        if (sck_o == prev_sck) stray++;
      end
      if (done_o && done_at < 0) begin
        done_at   = t;
        busy_done = int'(busy_o);
        sck_done  = int'(sck_o);
      end
      prev_sck = sck_o;
    end
    chk($sformatf("v%0d_busy_t0", idx), busy_t0, 1);
    chk($sformatf("v%0d_first_edge", idx), first, v.e_first);
    chk($sformatf("v%0d_last_edge", idx), last, v.e_last);
    chk($sformatf("v%0d_done", idx), done_at, v.e_done);
    chk($sformatf("v%0d_edges", idx), edges, v.e_edges);
    chk($sformatf("v%0d_shifts", idx), nsh, v.e_shift);
    chk($sformatf("v%0d_samples", idx), nsa, v.e_sample);
    chk($sformatf("v%0d_first_shift", idx), fsh, v.e_fsh);
    chk($sformatf("v%0d_last_shift", idx), lsh, v.e_lsh);
    chk($sformatf("v%0d_first_sample", idx), fsa, v.e_fsa);
    chk($sformatf("v%0d_last_sample", idx), lsa, v.e_lsa);
    chk($sformatf("v%0d_unpaired_strobes", idx), stray, (v.cpha != 0) ? 0 : 1);
    chk($sformatf("v%0d_busy_at_done", idx), busy_done, 0);
    chk($sformatf("v%0d_sck_at_done", idx), sck_done, v.cpol);
    div_i = '0; nbits_i = '0; cpha_i = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a, cnt_b, t_a, t_b, ne;
    //        div nb cpol cpha first last  done  edges sh  sa  fsh lsh    fsa  lsa
    vt[0] = '{1,   7, 0, 0,  3,    33,   35,   16,   8,  8,  1,  29,    3,   31};
    vt[1] = '{0,   0, 1, 1,  2,    3,    4,    2,    1,  1,  2,  2,     3,   3};
    vt[2] = '{2,   3, 1, 0,  4,    25,   28,   8,    4,  4,  1,  19,    4,   22};
    vt[3] = '{0,   1, 0, 1,  2,    5,    6,    4,    2,  2,  2,  4,     3,   5};
    vt[4] = '{4,   5, 1, 1,  6,    61,   66,   12,   6,  6,  6,  56,    11,  61};
    vt[5] = '{255, 63, 0, 1, 257,  32769, 33025, 128, 64, 64, 257, 32513, 513, 32769};

    #12;
    chk("rst_sck", int'(sck_o), 0);
    chk("rst_shift", int'(shift_o), 0);
    chk("rst_sample", int'(sample_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // Asynchronous reset in the middle of a burst, while sck is high.
    go(1, 7, 0, 0);
    repeat (7) @(posedge clk);
    #2;
    chk("midrst_sck_before", int'(sck_o), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_sck", int'(sck_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_strobes", int'(shift_o) + int'(sample_o) + int'(done_o), 0);
    cpol_i = 1'b1;
    #5; rst_n = 1'b1;
    cnt_a = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      cnt_a += int'(busy_o) + int'(done_o);
    end
    chk("midrst_idle_sck", int'(sck_o), 1);
    chk("midrst_no_activity", cnt_a, 0);

    // abort together with start in IDLE: nothing starts.
    @(posedge clk); #1; start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0; abort_i = 1'b0;
    cnt_a = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      cnt_a += int'(busy_o) + int'(shift_o) + int'(sample_o) + int'(done_o);
    end
    chk("abort_start_idle", cnt_a, 0);

    // Abort in the cycle that would produce edge 5 (cycle 12, div=1).
    go(1, 7, 1, 0);
    repeat (11) @(posedge clk);
    #1; abort_i = 1'b1;
    @(negedge clk);
    chk("abort_sck_pre", int'(sck_o), 0);
    @(posedge clk); #1; abort_i = 1'b0;
    @(negedge clk);
    chk("abort_sck_cpol", int'(sck_o), 1);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_strobes", int'(shift_o) + int'(sample_o), 0);
    cnt_a = 0; cnt_b = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      cnt_a += int'(done_o);
      cnt_b += int'(busy_o) + (sck_o != 1'b1 ? 1 : 0);
    end
    chk("abort_no_done", cnt_a, 0);
    chk("abort_stays_idle", cnt_b, 0);

    // start_i held through a burst (ignored while busy), accepted in the done cycle.
    div_i = 8'd1; nbits_i = 6'd1; cpol_i = 1'b0; cpha_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b1;
    t_a = -1; t_b = -1; cnt_a = 0; cnt_b = 0;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk); #1;
      if (t == 12) start_i = 1'b0;
      @(negedge clk);
      if (done_o) begin
        cnt_a++;
        if (t_a < 0) t_a = t; else if (t_b < 0) t_b = t;
      end
      if (t == 12) cnt_b = int'(busy_o);
    end
    chk("b2b_done1", t_a, 11);
    chk("b2b_done2", t_b, 22);
    chk("b2b_busy_restart", cnt_b, 1);
    chk("b2b_done_count", cnt_a, 2);

    // stall_i held for 10 cycles at edge 2 (div=3).
    go(3, 3, 0, 0);
    t_a = -1; t_b = -1; cnt_a = -1; ne = 0; cnt_b = -1;
    begin
      logic prev;
      prev = 1'b0;
      for (int t = 1; t <= 60; t++) begin
        if (t > 1) begin @(posedge clk); #1; end
        stall_i = (t >= 12 && t <= 21);
        @(negedge clk);
        if (sck_o != prev) begin
          if (ne == 1) cnt_b = t;
          if (ne == 2) t_a = t;
          if (ne == 7) t_b = t;
          ne++;
        end
        if (done_o && cnt_a < 0) cnt_a = t;
        prev = sck_o;
      end
    end
    stall_i = 1'b0;
    chk("stall_edge1", cnt_b, 9);
    chk("stall_edge2", t_a, 13 + STALL_DLY);
    chk("stall_edge7", t_b, 33 + STALL_DLY);
    chk("stall_done", cnt_a, 37 + STALL_DLY);
    chk("stall_edges", ne, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
